// File: rtl/sextium_avalon_fifo_slave_if.sv
// Avalon-MM bus bundle between the Sextium III I/O master and the FIFO slave.
interface sextium_avalon_fifo_slave_if;
  logic [31:0] address;
  logic        read;
  logic [15:0] readdata;
  logic        write;
  logic [15:0] writedata;
  logic        waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/sextium_avalon_fifo_slave.sv
// Avalon-MM FIFO slave: RX (stream -> bus) and TX (bus -> stream) FWFT FIFOs with waitrequest stalls.
// Optional status register at STATUS_ADDR when SEXTIUM_FIFO_STATUS_EN is defined.
module sextium_avalon_fifo_slave_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        head,
  output logic [DEPTH_LOG2:0] count
);
  logic [W-1:0]          mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

module sextium_avalon_fifo_slave #(
  parameter logic [31:0] READ_FIFO_ADDR  = 32'h200006,
  parameter logic [31:0] WRITE_FIFO_ADDR = 32'h200008,
`ifdef SEXTIUM_FIFO_STATUS_EN
  parameter logic [31:0] STATUS_ADDR     = 32'h20000A,
`endif
  parameter int unsigned DEPTH_LOG2      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  sextium_avalon_fifo_slave_if.slave bus,
  input  logic [15:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [15:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int RX = 0;
  localparam int TX = 1;

  logic [1:0]               push, pop, empty, full;
  logic [1:0][15:0]         wdata, head;
  logic [1:0][DEPTH_LOG2:0] count;
  logic                     rd_rx, wr_tx;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    sextium_avalon_fifo_slave_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(16)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (wdata[i]),
      .head  (head[i]),
      .count (count[i])
    );
    assign empty[i] = (count[i] == '0);
    assign full[i]  = count[i][DEPTH_LOG2];
  end

  // A concurrent read beats a write; the write is simply ignored.
  assign rd_rx = bus.read & (bus.address == READ_FIFO_ADDR);
  assign wr_tx = bus.write & ~bus.read & (bus.address == WRITE_FIFO_ADDR);

  assign bus.waitrequest = (rd_rx & empty[RX]) | (wr_tx & full[TX]);

  assign in_ready  = ~full[RX];
  assign push[RX]  = in_valid & ~full[RX];
  assign wdata[RX] = in_data;
  assign pop[RX]   = rd_rx & ~empty[RX];

  assign push[TX]  = wr_tx & ~full[TX];
  assign wdata[TX] = bus.writedata;
  assign out_valid = ~empty[TX];
  assign pop[TX]   = out_valid & out_ready;
  assign out_data  = empty[TX] ? 16'h0000 : head[TX];

`ifdef SEXTIUM_FIFO_STATUS_EN
  logic        st_rd;
  logic [15:0] status;
  assign st_rd  = bus.read & (bus.address == STATUS_ADDR);
  assign status = {8'(count[RX]), 4'b0000, empty[TX], full[RX], ~full[TX], ~empty[RX]};
`endif

  always_comb begin
    bus.readdata = 16'h0000;
    if (pop[RX]) bus.readdata = head[RX];
`ifdef SEXTIUM_FIFO_STATUS_EN
    else if (st_rd) bus.readdata = status;
`endif
  end
endmodule
